sc_spi_xfer: RTL and testbench

SPI transfer sequencer and data buffer. It sits directly upstream of the SPI protocol controller, `sc_spi_spc`. It holds a 16-word TX buffer that the engine reads through its TX word pointer, and captures engine RX words into a 16-word RX buffer. It launches one engine transfer per host command and reports completion with a single-cycle done pulse.

---
 rtl/sc_spi_xfer.sv | 132 +++++++++++++
 tb/tb_sc_spi_xfer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_spi_xfer.sv
// Transfer sequencer in front of the SPI engine: latches per-transfer settings,
// holds the TX word buffer for the engine and captures returned RX words.
module sc_spi_xfer #(
    parameter int NUM_WORDS = 16
) (
    input  logic        SPICLK,
    input  logic        SYSRSTB,
    input  logic        XSTART,
    input  logic [8:0]  XLEN,
    input  logic [4:0]  XCSSEL,
    input  logic        XCSEXT,
    input  logic        XBORDER,
    output logic        XBUSY,
    output logic        XDONE,
    output logic        XOVR,
    input  logic        XOVRCLR,
    input  logic        TXWE,
    input  logic [3:0]  TXWADDR,
    input  logic [31:0] TXWDATA,
    input  logic [3:0]  RXRADDR,
    output logic [31:0] RXRDATA,
    output logic [4:0]  RXCNT,
    output logic        SPISTART,
    input  logic        SPIBUSY,
    output logic [8:0]  DWIDTH,
    output logic [4:0]  CSSEL,
    output logic        CSEXTEND,
    output logic        BORDER,
    input  logic [3:0]  TXDPT,
    output logic [31:0] TXDATA,
    input  logic [31:0] RXDATA,
    input  logic        RXVALID,
    input  logic [3:0]  RXDPT
);
    typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

    state_t                        state_q;
    logic [NUM_WORDS-1:0][31:0]    txbuf_q;
    logic [NUM_WORDS-1:0][31:0]    rxbuf_q;
    logic [31:0]                   rxrdata_q;
    logic [4:0]                    rxcnt_q;
    logic [8:0]                    dwidth_q;
    logic [4:0]                    cssel_q;
    logic                          csext_q;
    logic                          border_q;
    logic                          spistart_q;
    logic                          xbusy_q;
    logic                          xdone_q;
    logic                          xovr_q;
    logic                          last_q;
    logic                          capture;
    logic                          last_hit;

    assign capture  = RXVALID && (state_q == REQ || state_q == RUN);
    // The final word and the engine going idle can land in the same cycle.
    assign last_hit = capture && (RXDPT == dwidth_q[8:5]);

    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q    <= IDLE;
            spistart_q <= 1'b0;
            xbusy_q    <= 1'b0;
            xdone_q    <= 1'b0;
            xovr_q     <= 1'b0;
            rxcnt_q    <= '0;
            last_q     <= 1'b0;
            dwidth_q   <= '0;
            cssel_q    <= '0;
            csext_q    <= 1'b0;
            border_q   <= 1'b0;
        end else begin
            xdone_q <= 1'b0;
            case (state_q)
                IDLE: if (XSTART) begin
                    dwidth_q   <= XLEN;
                    cssel_q    <= XCSSEL;
                    csext_q    <= XCSEXT;
                    border_q   <= XBORDER;
                    rxcnt_q    <= '0;
                    last_q     <= 1'b0;
                    spistart_q <= 1'b1;
                    xbusy_q    <= 1'b1;
                    state_q    <= REQ;
                end
                REQ: if (SPIBUSY) begin
                    spistart_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: if (!SPIBUSY && (last_q || last_hit)) begin
                    xdone_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    xbusy_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (capture) begin
                if (rxcnt_q != 5'd16) rxcnt_q <= rxcnt_q + 5'd1;
                if (last_hit) last_q <= 1'b1;
            end
            if (XSTART && xbusy_q) xovr_q <= 1'b1;
            else if (XOVRCLR)      xovr_q <= 1'b0;
        end
    end

    // Buffers are flops so reset can clear them along with everything else.
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            txbuf_q   <= '0;
            rxbuf_q   <= '0;
            rxrdata_q <= '0;
        end else begin
            if (TXWE && state_q == IDLE) txbuf_q[TXWADDR] <= TXWDATA;
            if (capture) rxbuf_q[RXDPT] <= RXDATA;
            rxrdata_q <= rxbuf_q[RXRADDR];
        end
    end

    assign TXDATA   = txbuf_q[TXDPT];
    assign RXRDATA  = rxrdata_q;
    assign RXCNT    = rxcnt_q;
    assign SPISTART = spistart_q;
    assign XBUSY    = xbusy_q;
    assign XDONE    = xdone_q;
    assign XOVR     = xovr_q;
    assign DWIDTH   = dwidth_q;
    assign CSSEL    = cssel_q;
    assign CSEXTEND = csext_q;
    assign BORDER   = border_q;
endmodule

// File: tb/tb_sc_spi_xfer.sv
// Bench for sc_spi_xfer: the bench plays host and loopback SPI engine, with
// word-level reference buffers for TX and RX contents.
module tb_sc_spi_xfer;
    logic        SPICLK = 1'b0;
    logic        SYSRSTB = 1'b1;
    logic        XSTART = 1'b0;
    logic [8:0]  XLEN = '0;
    logic [4:0]  XCSSEL = '0;
    logic        XCSEXT = 1'b0;
    logic        XBORDER = 1'b0;
    logic        XBUSY, XDONE, XOVR;
    logic        XOVRCLR = 1'b0;
    logic        TXWE = 1'b0;
    logic [3:0]  TXWADDR = '0;
    logic [31:0] TXWDATA = '0;
    logic [3:0]  RXRADDR = '0;
    logic [31:0] RXRDATA;
    logic [4:0]  RXCNT;
    logic        SPISTART;
    logic        SPIBUSY = 1'b0;
    logic [8:0]  DWIDTH;
    logic [4:0]  CSSEL;
    logic        CSEXTEND, BORDER;
    logic [3:0]  TXDPT = '0;
    logic [31:0] TXDATA;
    logic [31:0] RXDATA = '0;
    logic        RXVALID = 1'b0;
    logic [3:0]  RXDPT = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] tx_ref [16];
    logic [31:0] rx_ref [16];

    sc_spi_xfer #(.NUM_WORDS(16)) dut (
        .SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .XSTART(XSTART), .XLEN(XLEN),
        .XCSSEL(XCSSEL), .XCSEXT(XCSEXT), .XBORDER(XBORDER), .XBUSY(XBUSY),
        .XDONE(XDONE), .XOVR(XOVR), .XOVRCLR(XOVRCLR), .TXWE(TXWE),
        .TXWADDR(TXWADDR), .TXWDATA(TXWDATA), .RXRADDR(RXRADDR), .RXRDATA(RXRDATA),
        .RXCNT(RXCNT), .SPISTART(SPISTART), .SPIBUSY(SPIBUSY), .DWIDTH(DWIDTH),
        .CSSEL(CSSEL), .CSEXTEND(CSEXTEND), .BORDER(BORDER), .TXDPT(TXDPT),
        .TXDATA(TXDATA), .RXDATA(RXDATA), .RXVALID(RXVALID), .RXDPT(RXDPT)
    );

    always #5 SPICLK = ~SPICLK;

    always @(negedge SPICLK) if (SYSRSTB && XDONE === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge SPICLK); #1;
    endtask

    task automatic clear_refs;
        for (int i = 0; i < 16; i++) begin tx_ref[i] = '0; rx_ref[i] = '0; end
    endtask

    task automatic read_rx_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            RXRADDR = 4'(a);
            tick;
            checks++; if (RXRDATA !== rx_ref[a]) begin errors++; $display("FAIL %s rxbuf[%0d]: got %h exp %h", tag, a, RXRDATA, rx_ref[a]); end
        end
    endtask

    // mode: 0 plain, 1 overrun, 2 write while busy, 3 settings change, 4 reset in RUN
    task automatic do_xfer(input logic [8:0] len, input logic [4:0] cs, input logic ext,
                           input logic bo, input int mode);
        int n;
        int d0;
        logic [31:0] old;
        n  = int'(len) / 32 + 1;
        d0 = done_cnt;
        for (int i = 1; i < n; i++) begin
            TXWE = 1'b1; TXWADDR = 4'(i); TXWDATA = tx_ref[i]; tick;
        end
        TXWE = 1'b1; TXWADDR = 4'd0; TXWDATA = tx_ref[0];
        XSTART = 1'b1; XLEN = len; XCSSEL = cs; XCSEXT = ext; XBORDER = bo;
        tick;
        TXWE = 1'b0; XSTART = 1'b0;
        checks++; if (XBUSY !== 1'b1) begin errors++; $display("FAIL start_busy: got %b exp 1", XBUSY); end
        checks++; if (SPISTART !== 1'b1) begin errors++; $display("FAIL start_req: got %b exp 1", SPISTART); end
        checks++; if ({DWIDTH, CSSEL, CSEXTEND, BORDER} !== {len, cs, ext, bo}) begin errors++;
            $display("FAIL latch: got %0d/%0d/%b/%b exp %0d/%0d/%b/%b", DWIDTH, CSSEL, CSEXTEND, BORDER, len, cs, ext, bo); end
        repeat ($urandom_range(0, 2)) begin
            tick;
            checks++; if (SPISTART !== 1'b1) begin errors++; $display("FAIL req_hold: got %b exp 1", SPISTART); end
        end
        SPIBUSY = 1'b1;
        tick;
        checks++; if (SPISTART !== 1'b0) begin errors++; $display("FAIL req_drop: got %b exp 0", SPISTART); end
        if (mode == 1) begin
            XSTART = 1'b1; XLEN = ~len; XCSSEL = ~cs; tick;
            checks++; if (XOVR !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b exp 1", XOVR); end
            XSTART = 1'b0; XOVRCLR = 1'b1; tick;
            checks++; if (XOVR !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b exp 0", XOVR); end
            XSTART = 1'b1; tick;
            checks++; if (XOVR !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b exp 1", XOVR); end
            XSTART = 1'b0; XOVRCLR = 1'b0;
        end else if (mode == 2) begin
            TXWE = 1'b1; TXWADDR = 4'd0; TXWDATA = 32'hDEADBEEF; tick; TXWE = 1'b0;
        end else if (mode == 3) begin
            XLEN = len ^ 9'h1FF; XCSSEL = ~cs; XCSEXT = ~ext; XBORDER = ~bo; tick;
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick;
                checks++; if (SPISTART !== 1'b0) begin errors++; $display("FAIL run_req: got %b exp 0", SPISTART); end
            end
            if (mode == 4 && i == 1) begin
                SYSRSTB = 1'b0; #1;
                checks++; if ({SPISTART, XBUSY, XDONE, XOVR} !== 4'b0) begin errors++; $display("FAIL rst_ctl: got %b exp 0000", {SPISTART, XBUSY, XDONE, XOVR}); end
                checks++; if (RXCNT !== 5'd0) begin errors++; $display("FAIL rst_rxcnt: got %0d exp 0", RXCNT); end
                checks++; if (DWIDTH !== 9'd0) begin errors++; $display("FAIL rst_dwidth: got %0d exp 0", DWIDTH); end
                SPIBUSY = 1'b0; RXVALID = 1'b0; TXDPT = 4'd0; #1;
                checks++; if (TXDATA !== 32'd0) begin errors++; $display("FAIL rst_txbuf: got %h exp 0", TXDATA); end
                tick; SYSRSTB = 1'b1; tick;
                clear_refs;
                return;
            end
            TXDPT = 4'(i); #1;
            checks++; if (TXDATA !== tx_ref[i]) begin errors++; $display("FAIL txdata[%0d]: got %h exp %h", i, TXDATA, tx_ref[i]); end
            old = rx_ref[i];
            RXDATA = TXDATA; RXDPT = 4'(i); RXVALID = 1'b1; RXRADDR = 4'(i);
            tick;
            RXVALID = 1'b0;
            rx_ref[i] = tx_ref[i];
            checks++; if (RXRDATA !== old) begin errors++; $display("FAIL rd_old[%0d]: got %h exp %h", i, RXRDATA, old); end
            checks++; if (RXCNT !== 5'(i + 1)) begin errors++; $display("FAIL rxcnt_run: got %0d exp %0d", RXCNT, i + 1); end
            checks++; if (DWIDTH !== len) begin errors++; $display("FAIL dwidth_run: got %0d exp %0d", DWIDTH, len); end
        end
        repeat ($urandom_range(0, 2)) begin
            tick;
            checks++; if (XDONE !== 1'b0) begin errors++; $display("FAIL early_done: got %b exp 0", XDONE); end
        end
        SPIBUSY = 1'b0;
        tick;
        checks++; if ({XDONE, XBUSY} !== 2'b11) begin errors++; $display("FAIL done_pulse: got done/busy %b exp 11", {XDONE, XBUSY}); end
        tick;
        checks++; if ({XDONE, XBUSY} !== 2'b00) begin errors++; $display("FAIL done_end: got done/busy %b exp 00", {XDONE, XBUSY}); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (RXCNT !== 5'(n)) begin errors++; $display("FAIL rxcnt: got %0d exp %0d", RXCNT, n); end
        checks++; if ({DWIDTH, CSSEL, CSEXTEND, BORDER} !== {len, cs, ext, bo}) begin errors++;
            $display("FAIL latch_end: got %0d/%0d/%b/%b exp %0d/%0d/%b/%b", DWIDTH, CSSEL, CSEXTEND, BORDER, len, cs, ext, bo); end
        checks++; if (XOVR !== (mode == 1)) begin errors++; $display("FAIL xovr_end: got %b exp %b", XOVR, mode == 1); end
        TXDPT = 4'd0; #1;
        checks++; if (TXDATA !== tx_ref[0]) begin errors++; $display("FAIL txbuf0_end: got %h exp %h", TXDATA, tx_ref[0]); end
    endtask

    task automatic test_reset;
        #2 SYSRSTB = 1'b0;
        tick; tick;
        checks++; if ({SPISTART, XBUSY, XDONE, XOVR} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b exp 0000", {SPISTART, XBUSY, XDONE, XOVR}); end
        checks++; if ({RXCNT, RXRDATA} !== '0) begin errors++; $display("FAIL reset_rx: got cnt %0d data %h exp 0", RXCNT, RXRDATA); end
        checks++; if ({DWIDTH, CSSEL, CSEXTEND, BORDER} !== '0) begin errors++; $display("FAIL reset_eng: got %h exp 0", {DWIDTH, CSSEL, CSEXTEND, BORDER}); end
        SYSRSTB = 1'b1;
        clear_refs;
        TXDPT = 4'd7; #1;
        checks++; if (TXDATA !== 32'd0) begin errors++; $display("FAIL reset_txbuf: got %h exp 0", TXDATA); end
        read_rx_all("reset");
    endtask

    task automatic test_loopback32;
        tx_ref[0] = 32'hA5C3_0F81;
        do_xfer(9'd31, 5'd3, 1'b0, 1'b1, 0);
        read_rx_all("lb32");
    endtask

    task automatic test_loopback72;
        tx_ref[0] = 32'h11111111; tx_ref[1] = 32'h22222222; tx_ref[2] = 32'h33000000;
        do_xfer(9'd71, 5'd17, 1'b1, 1'b0, 0);
        read_rx_all("lb72");
    endtask

    task automatic test_overrun;
        tx_ref[0] = $urandom; tx_ref[1] = $urandom;
        do_xfer(9'd40, 5'd5, 1'b0, 1'b0, 1);
        repeat (3) tick;
        checks++; if (XBUSY !== 1'b0) begin errors++; $display("FAIL ovr_discard: got busy %b exp 0", XBUSY); end
        XOVRCLR = 1'b1; tick; XOVRCLR = 1'b0;
        checks++; if (XOVR !== 1'b0) begin errors++; $display("FAIL ovr_clear_idle: got %b exp 0", XOVR); end
    endtask

    task automatic test_write_busy;
        tx_ref[0] = 32'h0BADF00D;
        do_xfer(9'd20, 5'd1, 1'b0, 1'b1, 2);
    endtask

    task automatic test_latch;
        tx_ref[0] = $urandom; tx_ref[1] = $urandom; tx_ref[2] = $urandom;
        do_xfer(9'd90, 5'd9, 1'b1, 1'b1, 3);
    endtask

    task automatic test_random;
        logic [8:0] len;
        for (int k = 0; k < 8; k++) begin
            len = 9'($urandom_range(0, 511));
            for (int i = 0; i < 16; i++) tx_ref[i] = $urandom;
            do_xfer(len, 5'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        read_rx_all("random");
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            tx_ref[0] = $urandom;
            do_xfer(9'($urandom_range(0, 31)), 5'(k), 1'b0, 1'b0, 0);
        end
    endtask

    task automatic test_reset_run;
        for (int i = 0; i < 4; i++) tx_ref[i] = $urandom;
        do_xfer(9'd127, 5'd2, 1'b0, 1'b0, 4);
        read_rx_all("rst_run");
        tx_ref[0] = 32'hCAFE0001; tx_ref[1] = 32'hCAFE0002;
        do_xfer(9'd63, 5'd4, 1'b0, 1'b1, 0);
        read_rx_all("after_rst");
    endtask

    initial begin
        test_reset;
        test_loopback32;
        test_loopback72;
        test_overrun;
        test_write_busy;
        test_latch;
        test_random;
        test_back_to_back;
        test_reset_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
